// File: rtl/adder_accum.sv
// adder_accum: frame accumulator placed directly after the 32-bit adder.
// It takes one {carry, sum} result per input handshake and adds together a
// programmable number of results. The frame total is then presented on a
// valid/ready output port.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready input handshake for one adder result
//   in_sum, in_carry  adder result; the beat value is {in_carry, in_sum}
//   frame_len         beats per frame, sampled on the first beat (0 means 1)
//   out_valid/out_ready output handshake for the frame total
//   out_acc           frame total (ACC_W bits)
//   out_count         number of beats in the frame
//   out_ovf           the total carried out of ACC_W bits during the frame
//
// Build option
//   ADDER_ACCUM_SAT_EN  when defined, an overflowing frame clamps the
//                       accumulator to all-ones. Otherwise it wraps modulo
//                       2^ACC_W. out_ovf is set in both cases.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for the first beat of a frame; in_ready = 1
// ACCUM  | adding further beats until the latched length is reached
// HOLD   | total presented on the output port; in_ready = 0

module adder_accum #(
   parameter int ACC_W = 48,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_sum,
   input  logic             in_carry,
   input  logic [CNT_W-1:0] frame_len,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             ovf_q, ovf_d;

   logic [32:0]      beat_raw;
   logic [ACC_W-1:0] beat_v;
   logic [ACC_W:0]   sum_w;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] first_len;
   logic             accept;

   assign beat_raw  = {in_carry, in_sum};
   assign beat_v    = ACC_W'(beat_raw);
   // One extra bit so the carry out of the accumulator is visible.
   assign sum_w     = {1'b0, acc_q} + {1'b0, beat_v};
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign first_len = (frame_len == '0) ? CNT_W'(1) : frame_len;

   // Handshake flags decode from the state register only.
   assign in_ready  = (state_q != S_HOLD);
   assign out_valid = (state_q == S_HOLD);
   assign accept    = in_valid && in_ready;

   assign out_acc   = acc_q;
   assign out_count = cnt_q;
   assign out_ovf   = ovf_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               acc_d   = beat_v;
               cnt_d   = CNT_W'(1);
               len_d   = first_len;
               ovf_d   = 1'b0;
               state_d = (first_len == CNT_W'(1)) ? S_HOLD : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (accept) begin
               acc_d = sum_w[ACC_W-1:0];
               cnt_d = cnt_inc;
               if (sum_w[ACC_W]) begin
                  ovf_d = 1'b1;
`ifdef ADDER_ACCUM_SAT_EN
                  // Once clamped, any nonzero beat carries again, so acc stays all-ones.
                  acc_d = '1;
`endif
               end
               if (cnt_inc == len_q) state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_adder_accum.sv
// Bench for adder_accum. Two instances share one input stream: the default
// 48-bit build and a 34-bit build, so that overflow is exercised. A reference
// model sums whole frames arithmetically and queues the expected totals.
// Independent monitors pop the queues on each output handshake.
module tb_adder_accum;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_sum = '0;
   logic        in_carry = 1'b0;
   logic [7:0]  frame_len = '0;
   logic        out_ready = 1'b0;

   logic        in_ready_a, out_valid_a, out_ovf_a;
   logic [47:0] out_acc_a;
   logic [7:0]  out_count_a;
   logic        in_ready_b, out_valid_b, out_ovf_b;
   logic [33:0] out_acc_b;
   logic [7:0]  out_count_b;

   adder_accum u_dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_sum(in_sum), .in_carry(in_carry), .frame_len(frame_len),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
      .out_count(out_count_a), .out_ovf(out_ovf_a));

   adder_accum #(.ACC_W(34), .CNT_W(8)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_sum(in_sum), .in_carry(in_carry), .frame_len(frame_len),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
      .out_count(out_count_b), .out_ovf(out_ovf_b));

   always #5 clk = ~clk;

   typedef struct {
      longint unsigned acc;
      int              cnt;
      bit              ovf;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   int n_tests = 0;
   int n_fail  = 0;
   int ready_mode = 1;   // 0 random, 1 always ready, 2 never ready

   bit              in_frame = 0;
   int              len_m = 0;
   int              cnt_m = 0;
   longint unsigned sum_m = 0;

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Frame total from the true arithmetic sum of its beats.
   function automatic exp_t model(longint unsigned total, int cnt, int w);
      exp_t e;
      longint unsigned lim;
      lim   = 64'd1 << w;
      e.cnt = cnt;
      e.ovf = (total >= lim);
      if (!e.ovf)
         e.acc = total;
      else begin
`ifdef ADDER_ACCUM_SAT_EN
         e.acc = lim - 1;
`else
         e.acc = total % lim;
`endif
      end
      return e;
   endfunction

   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       out_ready = ($urandom_range(0, 2) != 0);
         1:       out_ready = 1'b1;
         default: out_ready = 1'b0;
      endcase
   end

   // Call at a negedge. Returns at a negedge with in_valid dropped.
   task automatic send_beat(input logic [32:0] v, input logic [7:0] flen);
      int t = 0;
      bit done = 0;
      in_valid  = 1'b1;
      {in_carry, in_sum} = v;
      frame_len = flen;
      while (!in_ready_a && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready_a) begin
         chk("in_ready_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (!in_frame) begin
         in_frame = 1;
         len_m    = (flen == 0) ? 1 : int'(flen);
         cnt_m    = 1;
         sum_m    = longint'(v);
      end else begin
         cnt_m++;
         sum_m += longint'(v);
      end
      if (cnt_m == len_m) begin
         qa.push_back(model(sum_m, cnt_m, 48));
         qb.push_back(model(sum_m, cnt_m, 34));
         in_frame = 0;
         done = 1;
      end
      @(negedge clk);
      if (done) begin
         chk("latency_out_valid", out_valid_a, 1);
         chk("hold_in_ready", in_ready_a, 0);
      end
      chk("b_in_ready_match", in_ready_b, in_ready_a);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((qa.size() != 0 || qb.size() != 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("queue_a_drained", qa.size(), 0);
      chk("queue_b_drained", qb.size(), 0);
   endtask

   // Monitor A
   logic [47:0] prev_acc_a;
   logic [7:0]  prev_cnt_a;
   logic        prev_ovf_a;
   bit          have_prev_a = 0;
   always @(negedge clk) begin
      if (rst) have_prev_a = 0;
      else if (out_valid_a) begin
         chk("a_in_ready_low", in_ready_a, 0);
         if (have_prev_a) begin
            chk("a_stable_acc", out_acc_a, prev_acc_a);
            chk("a_stable_cnt", out_count_a, prev_cnt_a);
            chk("a_stable_ovf", out_ovf_a, prev_ovf_a);
         end
         if (out_ready) begin
            have_prev_a = 0;
            if (qa.size() == 0) chk("a_unexpected_output", 1, 0);
            else begin
               exp_t e;
               e = qa.pop_front();
               chk("a_acc", out_acc_a, e.acc);
               chk("a_count", out_count_a, longint'(e.cnt));
               chk("a_ovf", out_ovf_a, longint'(e.ovf));
            end
         end else begin
            prev_acc_a = out_acc_a;
            prev_cnt_a = out_count_a;
            prev_ovf_a = out_ovf_a;
            have_prev_a = 1;
         end
      end
   end

   // Monitor B
   always @(negedge clk) begin
      if (!rst && out_valid_b && out_ready) begin
         if (qb.size() == 0) chk("b_unexpected_output", 1, 0);
         else begin
            exp_t e;
            e = qb.pop_front();
            chk("b_acc", out_acc_b, e.acc);
            chk("b_count", out_count_b, longint'(e.cnt));
            chk("b_ovf", out_ovf_b, longint'(e.ovf));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", out_valid_a, 0);
      chk("rst_out_acc", out_acc_a, 0);
      chk("rst_out_count", out_count_a, 0);
      chk("rst_out_ovf", out_ovf_a, 0);
      chk("rst_in_ready", in_ready_a, 1);
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back frame of three beats
      ready_mode = 1;
      send_beat({1'b0, 32'h56565656}, 8'd3);
      send_beat({1'b0, 32'hFFFFFFFF}, 8'd3);
      send_beat({1'b1, 32'h01010100}, 8'd3);
      chk("t1_acc", out_acc_a, 48'h000257575755);
      chk("t1_count", out_count_a, 3);
      chk("t1_ovf", out_ovf_a, 0);
      drain();

      // frame_len 0 acts as 1; a single bubble cycle
      send_beat({1'b1, 32'h00000000}, 8'd0);
      chk("t2_acc", out_acc_a, 48'h000100000000);
      chk("t2_count", out_count_a, 1);
      @(negedge clk);
      chk("t2_bubble_one_cycle", in_ready_a, 1);
      drain();

      // Output stalled with a beat waiting upstream
      ready_mode = 2;
      @(negedge clk);
      send_beat({1'b0, 32'h00001234}, 8'd1);
      in_valid = 1'b1;
      {in_carry, in_sum} = {1'b0, 32'h00000007};
      frame_len = 8'd2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_valid_held", out_valid_a, 1);
         chk("t3_in_ready_low", in_ready_a, 0);
         chk("t3_acc_held", out_acc_a, 48'h1234);
      end
      ready_mode = 1;
      send_beat({1'b0, 32'h00000007}, 8'd2);
      send_beat({1'b0, 32'h00000008}, 8'd2);
      chk("t3_next_frame", out_acc_a, 48'hF);
      drain();

      // Overflow of the 34-bit instance
      for (int i = 0; i < 3; i++) send_beat({1'b1, 32'hFFFFFFFF}, 8'd3);
      chk("t4_b_ovf", out_ovf_b, 1);
`ifdef ADDER_ACCUM_SAT_EN
      chk("t4_b_acc", out_acc_b, 34'h3FFFFFFFF);
`else
      chk("t4_b_acc", out_acc_b, 34'h1FFFFFFFD);
`endif
      drain();

      // Reset mid-frame
      send_beat({1'b0, 32'h11111111}, 8'd4);
      send_beat({1'b0, 32'h22222222}, 8'd4);
      rst = 1'b1;
      #1;
      chk("t5_rst_valid", out_valid_a, 0);
      chk("t5_rst_acc", out_acc_a, 0);
      chk("t5_rst_count", out_count_a, 0);
      chk("t5_rst_ovf", out_ovf_a, 0);
      chk("t5_rst_acc_b", out_acc_b, 0);
      in_frame = 0;
      @(negedge clk);
      rst = 1'b0;
      send_beat({1'b0, 32'h00000005}, 8'd1);
      chk("t5_acc", out_acc_a, 5);
      chk("t5_ovf", out_ovf_a, 0);
      drain();

      // Gaps between beats; a mid-frame length change is ignored
      send_beat({1'b0, 32'h99999999}, 8'd2);
      repeat (3) @(negedge clk);
      frame_len = 8'd7;
      send_beat({1'b0, 32'h05050505}, 8'd7);
      chk("t6_acc", out_acc_a, 48'h00009E9E9E9E);
      chk("t6_count", out_count_a, 2);
      drain();

      // Longest frame: 255 beats
      for (int i = 0; i < 255; i++) send_beat({1'b1, 32'hFFFFFFFF}, 8'd255);
      chk("t7_count", out_count_a, 255);
      drain();

      // Randomised frames with random gaps and random output back-pressure
      ready_mode = 0;
      for (int f = 0; f < 40; f++) begin
         logic [7:0] fl;
         fl = 8'($urandom_range(0, 6));
         send_beat({1'($urandom_range(0, 1)), 32'($urandom)}, fl);
         while (in_frame) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send_beat({1'($urandom_range(0, 1)), 32'($urandom)}, 8'($urandom_range(0, 9)));
         end
      end
      ready_mode = 1;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
